memory_arbiter: RTL

Round-robin arbiter that shares one memory slave among NUMBER_OF_MASTERS requesters using the team's address / dataOut / dataIn / readEnabled / writeEnabled / functionComplete handshake. Requesters connect through flattened per-master buses. The memory connects through the `MemoryInterface.master` modport. Only one transaction is outstanding at a time, and fairness rotates after every completed or abandoned access.

---
 rtl/memory_arbiter_if.sv | 30 +++
 rtl/memory_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/memory_arbiter_if.sv
// Memory slave handshake bundle shared by the arbiter (master side) and the memory (slave side).
interface MemoryInterface #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0]    dataOut;
  logic [DATA_WIDTH-1:0]    dataIn;
  logic                     readEnabled;
  logic                     writeEnabled;
  logic                     functionComplete;

  modport master (
    output address,
    output dataOut,
    output readEnabled,
    output writeEnabled,
    input  dataIn,
    input  functionComplete
  );

  modport slave (
    input  address,
    input  dataOut,
    input  readEnabled,
    input  writeEnabled,
    output dataIn,
    output functionComplete
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory slave among NUMBER_OF_MASTERS requesters,
// one outstanding transaction at a time, fairness rotating after each finished or abandoned access.
module memory_arbiter #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int NUMBER_OF_MASTERS = 4
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [NUMBER_OF_MASTERS*ADDRESS_WIDTH-1:0] masterAddress,
  input  logic [NUMBER_OF_MASTERS*DATA_WIDTH-1:0]    masterDataOut,
  input  logic [NUMBER_OF_MASTERS-1:0]               masterReadEnabled,
  input  logic [NUMBER_OF_MASTERS-1:0]               masterWriteEnabled,
  output logic [NUMBER_OF_MASTERS*DATA_WIDTH-1:0]    masterDataIn,
  output logic [NUMBER_OF_MASTERS-1:0]               masterFunctionComplete,
  MemoryInterface.master                             memoryInterface,
  output logic [NUMBER_OF_MASTERS-1:0]               grant,
  output logic                                       busy
);

  localparam int NM    = NUMBER_OF_MASTERS;
  localparam int IDX_W = $clog2(NM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NM - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_index_q, grant_index_d;
  logic [IDX_W-1:0] pointer_q, pointer_d;

  logic [NM-1:0]    request_s;
  logic             granted_req_s;
  logic [IDX_W-1:0] scan_idx_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_found_s;

  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    nxt = (idx == LAST_IDX) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
    return nxt;
  endfunction

  assign request_s     = masterReadEnabled | masterWriteEnabled;
  assign granted_req_s = request_s[grant_index_q];

  // Round-robin pick: first requester found scanning upward from the pointer, wrapping.
  always_comb begin
    scan_idx_s   = pointer_q;
    pick_idx_s   = pointer_q;
    pick_found_s = 1'b0;
    for (int off = 0; off < NM; off++) begin
      pick_idx_s   = (!pick_found_s && request_s[scan_idx_s]) ? scan_idx_s : pick_idx_s;
      pick_found_s = pick_found_s | request_s[scan_idx_s];
      scan_idx_s   = next_index(scan_idx_s);
    end
  end

  // Next-state logic for the access FSM, grant index and fairness pointer.
  always_comb begin
    state_d       = state_q;
    grant_index_d = grant_index_q;
    pointer_d     = pointer_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          grant_index_d = pick_idx_s;
          state_d       = ST_ACCESS;
        end else begin
          state_d       = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (memoryInterface.functionComplete) begin
          state_d = ST_FINISH;
        end else if (!granted_req_s) begin
          // Master gave up before completion: release the slave and rotate.
          state_d   = ST_IDLE;
          pointer_d = next_index(grant_index_q);
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_FINISH: begin
        if (!granted_req_s && !memoryInterface.functionComplete) begin
          state_d   = ST_IDLE;
          pointer_d = next_index(grant_index_q);
        end else begin
          state_d = ST_FINISH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_index_q <= {IDX_W{1'b0}};
      pointer_q     <= {IDX_W{1'b0}};
    end else begin
      state_q       <= state_d;
      grant_index_q <= grant_index_d;
      pointer_q     <= pointer_d;
    end
  end

  // Combinational forwarding between the granted master and the memory.
  always_comb begin
    masterDataIn           = {(NM*DATA_WIDTH){1'b0}};
    masterFunctionComplete = {NM{1'b0}};
    if (state_q != ST_IDLE) begin
      memoryInterface.address      = masterAddress[grant_index_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      memoryInterface.dataOut      = masterDataOut[grant_index_q*DATA_WIDTH +: DATA_WIDTH];
      memoryInterface.readEnabled  = masterReadEnabled[grant_index_q];
      memoryInterface.writeEnabled = masterWriteEnabled[grant_index_q];
      masterFunctionComplete[grant_index_q]                   = memoryInterface.functionComplete;
      masterDataIn[grant_index_q*DATA_WIDTH +: DATA_WIDTH]    = memoryInterface.dataIn;
    end else begin
      memoryInterface.address      = {ADDRESS_WIDTH{1'b0}};
      memoryInterface.dataOut      = {DATA_WIDTH{1'b0}};
      memoryInterface.readEnabled  = 1'b0;
      memoryInterface.writeEnabled = 1'b0;
    end
  end

  // Ownership status decoded purely from registered state.
  always_comb begin
    grant = {NM{1'b0}};
    busy  = (state_q != ST_IDLE);
    if (state_q != ST_IDLE) begin
      grant[grant_index_q] = 1'b1;
    end else begin
      grant = {NM{1'b0}};
    end
  end

endmodule
